// File: rtl/systolic_outer_acc_if.sv
// Bus bundle for systolic_outer_acc.
//   ena            global enable (all state holds when low)
//   mode[1:0]      00 load/compute, 01 readout, 10 clear, 11 idle
//   in_data/valid  operand byte stream into the tile
//   in_ready       tile can take the byte offered this cycle
//   out_data/valid registered readout byte stream
//   busy           compute sweep running
//   sat_flag       sticky accumulator clamp indicator
// master = driver (wrapper / bench), slave = the tile.
interface systolic_outer_acc_if;
    logic       ena;
    logic [1:0] mode;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       sat_flag;

    modport master (
        output ena, mode, in_data, in_valid,
        input  in_ready, out_data, out_valid, busy, sat_flag
    );
    modport slave (
        input  ena, mode, in_data, in_valid,
        output in_ready, out_data, out_valid, busy, sat_flag
    );
endinterface

// File: rtl/systolic_outer_acc.sv
// systolic_outer_acc: byte-loaded NxN outer-product accumulator tile.
// A and B vectors (N signed DW-bit operands each, MSB byte first) stream in
// over an 8-bit port into shadow registers; the final byte hands them to the
// working registers and starts an N-cycle sweep that adds row r of A*B^T into
// C each cycle. C is read back byte-serially, MSB byte first, row major.
// Ports: clk, rst_n (synchronous, active low), bus (systolic_outer_acc_if.slave).
// Build option: define SATURATE_EN to clamp each accumulate to the signed
// ACC_W range and raise the sticky sat_flag; otherwise arithmetic wraps and
// sat_flag stays 0.

// One column lane: acc + a*b with sign-extended product.
module systolic_outer_acc_mac #(
    parameter int DW    = 8,
    parameter int ACC_W = 24
) (
    input  logic signed [DW-1:0]    a_i,
    input  logic signed [DW-1:0]    b_i,
    input  logic signed [ACC_W-1:0] acc_i,
    output logic [ACC_W-1:0]        acc_o,
    output logic                    clamp_o
);
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] ext;

    assign prod = a_i * b_i;
    assign ext  = ACC_W'(prod);

`ifdef SATURATE_EN
    logic [ACC_W:0] sum;

    // One guard bit: overflow when the guard and sign bits disagree.
    assign sum = {acc_i[ACC_W-1], acc_i} + {ext[ACC_W-1], ext};

    always_comb begin
        clamp_o = sum[ACC_W] ^ sum[ACC_W-1];
        acc_o   = sum[ACC_W-1:0];
        if (clamp_o)
            acc_o = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    assign acc_o   = acc_i + ext;
    assign clamp_o = 1'b0;
`endif
endmodule

module systolic_outer_acc #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int ACC_W = 24
) (
    input logic            clk,
    input logic            rst_n,
    systolic_outer_acc_if.slave bus
);
    localparam int BPO = DW / 8;
    localparam int BPA = ACC_W / 8;
    localparam int NOP = 2 * N;
    localparam int AW  = (N > 1) ? $clog2(N) : 1;
    localparam int EW  = $clog2(NOP);
    localparam int OBW = (BPO > 1) ? $clog2(BPO) : 1;
    localparam int CW  = (N * N > 1) ? $clog2(N * N) : 1;
    localparam int RBW = (BPA > 1) ? $clog2(BPA) : 1;

    localparam logic [EW-1:0]  LEL_LAST = EW'(NOP - 1);
    localparam logic [OBW-1:0] LBY_LAST = OBW'(BPO - 1);
    localparam logic [CW-1:0]  REL_LAST = CW'(N * N - 1);
    localparam logic [RBW-1:0] RBY_LAST = RBW'(BPA - 1);
    localparam logic [AW-1:0]  ROW_LAST = AW'(N - 1);

    logic [1:0]     mode_q, mode_d;
    logic [EW-1:0]  lel_q, lel_d, lel_e;   // load operand index
    logic [OBW-1:0] lby_q, lby_d, lby_e;   // load byte within operand
    logic [CW-1:0]  rel_q, rel_d, rel_e;   // readout element index
    logic [RBW-1:0] rby_q, rby_d, rby_e;   // readout byte within element
    logic [AW-1:0]  row_q, row_d;
    logic           busy_q, busy_d;
    logic [7:0]     out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           sat_q, sat_d;

    logic [N-1:0][DW-1:0]      ain_q, ain_d, bin_q, bin_d, a_q, a_d, b_q, b_d;
    logic [N*N-1:0][ACC_W-1:0] c_q, c_d;

    logic [N-1:0][ACC_W-1:0] c_row, mac_sum;
    logic [N-1:0]            mac_clamp;

    logic mode_chg, last_byte, in_ready_c, accept;
    int   sh;

    always_comb begin
        for (int j = 0; j < N; j++)
            c_row[j] = c_q[CW'(int'(row_q) * N + j)];
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        systolic_outer_acc_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
            .a_i    (a_q[row_q]),
            .b_i    (b_q[j]),
            .acc_i  (c_row[j]),
            .acc_o  (mac_sum[j]),
            .clamp_o(mac_clamp[j])
        );
    end

    always_comb begin
        // Any mode change restarts both byte streams from index 0 this cycle.
        mode_chg = (bus.mode != mode_q);
        lel_e    = mode_chg ? '0 : lel_q;
        lby_e    = mode_chg ? '0 : lby_q;
        rel_e    = mode_chg ? '0 : rel_q;
        rby_e    = mode_chg ? '0 : rby_q;

        mode_d      = bus.mode;
        lel_d       = lel_e;
        lby_d       = lby_e;
        rel_d       = rel_e;
        rby_d       = rby_e;
        row_d       = row_q;
        busy_d      = busy_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        sat_d       = sat_q;
        ain_d       = ain_q;
        bin_d       = bin_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;

        // The final byte of a pair waits while the working registers are in use.
        last_byte  = (lel_e == LEL_LAST) && (lby_e == LBY_LAST);
        in_ready_c = !(busy_q && last_byte);
        accept     = bus.in_valid && in_ready_c && (bus.mode == 2'b00);

        sh = 8 * (BPA - 1 - int'(rby_e));

        if (busy_q) begin
            for (int j = 0; j < N; j++)
                c_d[CW'(int'(row_q) * N + j)] = mac_sum[j];
            sat_d = sat_q | (|mac_clamp);
            if (row_q == ROW_LAST) busy_d = 1'b0;
            else                   row_d  = row_q + 1'b1;
        end

        case (bus.mode)
            2'b00: begin
                if (accept) begin
                    if (int'(lel_e) < N)
                        ain_d[AW'(lel_e)] = DW'({ain_q[AW'(lel_e)], bus.in_data});
                    else
                        bin_d[AW'(int'(lel_e) - N)] = DW'({bin_q[AW'(int'(lel_e) - N)], bus.in_data});
                    if (lby_e == LBY_LAST) begin
                        lby_d = '0;
                        if (last_byte) begin
                            // Handoff includes the byte landing this cycle.
                            lel_d  = '0;
                            a_d    = ain_d;
                            b_d    = bin_d;
                            busy_d = 1'b1;
                            row_d  = '0;
                        end else begin
                            lel_d = lel_e + 1'b1;
                        end
                    end else begin
                        lby_d = lby_e + 1'b1;
                    end
                end
            end
            2'b01: begin
                if (!busy_q) begin
                    out_data_d  = 8'(c_q[rel_e] >> sh);
                    out_valid_d = 1'b1;
                    if (rby_e == RBY_LAST) begin
                        rby_d = '0;
                        rel_d = (rel_e == REL_LAST) ? '0 : rel_e + 1'b1;
                    end else begin
                        rby_d = rby_e + 1'b1;
                    end
                end
            end
            2'b10: begin
                c_d    = '0;
                sat_d  = 1'b0;
                busy_d = 1'b0;
                row_d  = '0;
                lel_d  = '0;
                lby_d  = '0;
                rel_d  = '0;
                rby_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q      <= 2'b00;
            lel_q       <= '0;
            lby_q       <= '0;
            rel_q       <= '0;
            rby_q       <= '0;
            row_q       <= '0;
            busy_q      <= 1'b0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            ain_q       <= '0;
            bin_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
        end else if (bus.ena) begin
            mode_q      <= mode_d;
            lel_q       <= lel_d;
            lby_q       <= lby_d;
            rel_q       <= rel_d;
            rby_q       <= rby_d;
            row_q       <= row_d;
            busy_q      <= busy_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
            ain_q       <= ain_d;
            bin_q       <= bin_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    // Clamps are never raised in the wrapping build, so this stays 0 there.
    assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_systolic_outer_acc.sv
module tb_systolic_outer_acc;
    logic       clk, rst_n;
    logic       ena, sel, in_valid;
    logic [1:0] mode;
    logic [7:0] in_data;

    systolic_outer_acc_if if0 ();
    systolic_outer_acc_if if1 ();

    assign if0.ena = ena & ~sel;
    assign if1.ena = ena & sel;
    assign if0.mode = mode;
    assign if1.mode = mode;
    assign if0.in_data = in_data;
    assign if1.in_data = in_data;
    assign if0.in_valid = in_valid;
    assign if1.in_valid = in_valid;

    systolic_outer_acc #(.N(4), .DW(8), .ACC_W(24)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    systolic_outer_acc #(.N(4), .DW(8), .ACC_W(16)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    wire       rdy = sel ? if1.in_ready  : if0.in_ready;
    wire       ov  = sel ? if1.out_valid : if0.out_valid;
    wire [7:0] od  = sel ? if1.out_data  : if0.out_data;
    wire       bz  = sel ? if1.busy      : if0.busy;
    wire       sf  = sel ? if1.sat_flag  : if0.sat_flag;

    int         total = 0;
    int         bad   = 0;
    int         stalls;
    int         cm [16];
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [7:0] rb [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        @(negedge clk);
        mode = 2'b00; in_valid = 1'b1; in_data = b;
        #1;
        t = 0;
        while (!rdy && t < 100) begin
            stalls++;
            @(negedge clk); #1;
            t++;
        end
        if (t >= 100) begin
            total++; bad++;
            $error("FAIL send_timeout observed=stalled expected=accept");
        end
    endtask

    task automatic load_pair();
        for (int i = 0; i < 4; i++) send(va[i]);
        for (int i = 0; i < 4; i++) send(vb[i]);
    endtask

    task automatic model_add();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                cm[i*4+j] += int'($signed(va[i])) * int'($signed(vb[j]));
    endtask

    task automatic wait_idle();
        int t;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (bz && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            total++; bad++;
            $error("FAIL busy_timeout observed=busy expected=idle");
        end
    endtask

    task automatic read_bytes(input int n);
        @(negedge clk);
        mode = 2'b01; in_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk($sformatf("ov%0d", k), 32'(ov), 32'd1);
            rb[k] = od;
        end
        mode = 2'b11;
    endtask

    task automatic do_clear();
        @(negedge clk);
        mode = 2'b10; in_valid = 1'b0;
        @(negedge clk);
        mode = 2'b11;
        for (int e = 0; e < 16; e++) cm[e] = 0;
    endtask

    task automatic check_all(input string tag);
        int e, b, exp;
        for (int k = 0; k < 48; k++) begin
            e   = k / 3;
            b   = k % 3;
            exp = (cm[e] >> (8 * (2 - b))) & 255;
            chk($sformatf("%s_b%0d", tag, k), 32'(rb[k]), 32'(exp));
        end
    endtask

    task automatic set_pair2();
        va[0] = 8'd1; va[1] = 8'd2; va[2] = 8'd3; va[3] = 8'd4;
        vb[0] = 8'd5; vb[1] = 8'd6; vb[2] = 8'd7; vb[3] = 8'd8;
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; ena = 1'b1; sel = 1'b0; mode = 2'b11; in_valid = 1'b0; in_data = 8'h00;
        stalls = 0;
        for (int e = 0; e < 16; e++) cm[e] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_in_ready", 32'(rdy), 32'd1);
        chk("rst_busy", 32'(bz), 32'd0);
        chk("rst_out_valid", 32'(ov), 32'd0);
        chk("rst_out_data", 32'(od), 32'd0);
        chk("rst_sat", 32'(sf), 32'd0);

        // Readout after reset: all zero, wraps after 48 bytes
        read_bytes(49);
        check_all("zero");
        chk("zero_wrap", 32'(rb[48]), 32'd0);

        // A=[1,2,3,4] B=[5,6,7,8]
        set_pair2();
        load_pair();
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        for (int t = 0; t < 12; t++) begin
            if (bz) cnt++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(cnt), 32'd4);
        model_add();
        read_bytes(51);
        check_all("p2");
        chk("p2_c00_lsb", 32'(rb[2]), 32'h05);
        chk("p2_c12_mid", 32'(rb[19]), 32'h00);
        chk("p2_c12_lsb", 32'(rb[20]), 32'h0E);
        chk("p2_c33_lsb", 32'(rb[47]), 32'h20);
        chk("p2_wrap", 32'(rb[50]), 32'h05);

        // Signed product: -1 * 2
        do_clear();
        chk("clr_sat", 32'(sf), 32'd0);
        va[0] = 8'hFF; va[1] = 8'h00; va[2] = 8'h00; va[3] = 8'h00;
        vb[0] = 8'h02; vb[1] = 8'h00; vb[2] = 8'h00; vb[3] = 8'h00;
        load_pair();
        wait_idle();
        model_add();
        read_bytes(48);
        check_all("neg");
        chk("neg_c00_b0", 32'(rb[0]), 32'hFF);
        chk("neg_c00_b1", 32'(rb[1]), 32'hFF);
        chk("neg_c00_b2", 32'(rb[2]), 32'hFE);
        chk("neg_c01_b2", 32'(rb[5]), 32'h00);

        // Back-to-back streaming: second pair loads during the first sweep
        do_clear();
        set_pair2();
        stalls = 0;
        load_pair();
        load_pair();
        wait_idle();
        model_add();
        model_add();
        chk("b2b_stalls", 32'(stalls), 32'd0);
        read_bytes(48);
        check_all("b2b");
        chk("b2b_c33_lsb", 32'(rb[47]), 32'h40);
        chk("b2b_c33_mid", 32'(rb[46]), 32'h00);

        // Partial load discarded by clear, then a full load
        do_clear();
        send(8'h11); send(8'h22); send(8'h33);
        do_clear();
        set_pair2();
        load_pair();
        wait_idle();
        model_add();
        read_bytes(48);
        check_all("part");
        chk("part_c00_lsb", 32'(rb[2]), 32'h05);
        chk("part_c33_lsb", 32'(rb[47]), 32'h20);

        // ACC_W=16 instance: (-128*-128) accumulated twice
        @(negedge clk);
        sel = 1'b1; mode = 2'b11;
        for (int i = 0; i < 4; i++) begin va[i] = 8'h80; vb[i] = 8'h80; end
        load_pair();
        load_pair();
        wait_idle();
        read_bytes(32);
`ifdef SATURATE_EN
        chk("w16_c00_msb", 32'(rb[0]), 32'h7F);
        chk("w16_c00_lsb", 32'(rb[1]), 32'hFF);
        chk("w16_c33_msb", 32'(rb[30]), 32'h7F);
        chk("w16_sat", 32'(sf), 32'd1);
`else
        chk("w16_c00_msb", 32'(rb[0]), 32'h80);
        chk("w16_c00_lsb", 32'(rb[1]), 32'h00);
        chk("w16_c33_msb", 32'(rb[30]), 32'h80);
        chk("w16_sat", 32'(sf), 32'd0);
`endif
        do_clear();
        chk("w16_clr_sat", 32'(sf), 32'd0);
        read_bytes(32);
        chk("w16_clr_c00_msb", 32'(rb[0]), 32'h00);
        chk("w16_clr_c00_lsb", 32'(rb[1]), 32'h00);
        chk("w16_clr_c33_lsb", 32'(rb[31]), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/systolic_outer_acc.md
Name: systolic_outer_acc

Overview:
- Parametrised successor to the byte-serial systolic tile: loads A and B operand vectors over an 8-bit port, then accumulates their outer product into an NxN accumulator array (C[i][j] += A[i]*B[j]).
- Operand registers are double-buffered, so the next vector pair can stream in while the current pair is computed.
- C is read out byte-serially. Adds a clear mode, flow control and optional saturation.
- Sits between the top-level pin wrapper (ui_in/uio/uo_out) and the user.

Parameters:
- N, 4, vector length; C is NxN.
- DW, 8, signed operand width; must be 8 or 16; BPO = DW/8 bytes per operand.
- ACC_W, 24, signed accumulator width; multiple of 8, >= 2*DW; BPA = ACC_W/8.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  global enable; when 0, all state holds
- mode  in  2  00 load/compute, 01 readout, 10 clear, 11 idle
- in_data  in  8  operand byte
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  byte accepted when in_valid & in_ready & ena & mode==00
- out_data  out  8  readout byte (registered)
- out_valid  out  1  out_data valid
- busy  out  1  compute sweep in progress
- sat_flag  out  1  sticky saturation indicator

Behaviour:
- Clock and reset: clk, with rst_n as the reset (synchronous, active-low).
- Reset:
  - Shadow regs ain/bin, working regs a/b and all C cleared to 0.
  - Load index, readout index and row counter cleared to 0.
  - Outputs: out_data=0, out_valid=0, busy=0, sat_flag=0, in_ready=1.
- Load (mode 00):
  - Byte index 0..2*N*BPO-1.
  - First N*BPO bytes fill ain[0..N-1], then N*BPO bytes fill bin[0..N-1].
  - Each operand is sent MSB byte first.
- Handoff:
  - On acceptance of the final byte, if not busy: next cycle a<=ain, b<=bin, busy=1, row=0, load index wraps to 0.
  - If busy when the final byte arrives, in_ready deasserts for that byte. The byte is not accepted and stays pending until busy falls.
- Compute:
  - In row cycle r, C[r][j] += a[r]*b[j] for all j (N parallel signed DWxDW multipliers).
  - Products are sign-extended to ACC_W.
  - Sweep lasts N cycles; busy drops the cycle after row N-1.
  - The load index keeps advancing during the sweep (double buffer).
- Arithmetic: without the optional feature, two's-complement wrap modulo 2^ACC_W.
- Readout (mode 01):
  - Each enabled cycle with busy=0 emits one byte; out_valid=1 one cycle later.
  - Order: C[0][0]..C[0][N-1], C[1][0]..C[N-1][N-1], each MSB byte first.
  - Index wraps to 0 after N*N*BPA bytes.
  - While busy: out_valid=0, index holds.
  - out_data holds its last value whenever out_valid=0.
- Clear (mode 10):
  - One cycle zeroes all C and sat_flag.
  - Load index and readout index reset to 0.
  - ain/bin/a/b untouched.
  - An in-flight sweep is aborted (busy<=0).
- Idle (mode 11): no state change except a running sweep completes.
- Mode change: any change of mode resets the load index and readout index to 0. A partially loaded vector pair is discarded; the sweep in progress continues.
- ena=0: everything freezes, including the sweep; outputs hold.
- rst_n low mid-operation: full reset as above on the next edge.

Optional Feature:
- Macro SATURATE_EN.
- When defined: each accumulate clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. sat_flag sets on any clamp and stays set until reset or clear mode.
- When undefined: wrap arithmetic; sat_flag tied 0.

Test Plan:
- Reset, then readout 48 bytes (N=4, DW=8, ACC_W=24) -> all 0x00; out_valid high from cycle 2; index wraps to C[0][0] on byte 49.
- Load A=[1,2,3,4], B=[5,6,7,8] -> busy high exactly 4 cycles. Readout gives:
  - C[0][0] = 00 00 05
  - C[1][2] = 00 00 0E
  - C[3][3] = 00 00 20
- Load A=[0xFF,0,0,0], B=[0x02,0,0,0] -> C[0][0] = FF FF FE (-2); all other C = 0.
- Back-to-back loads of the pair from the second scenario, streamed continuously (second pair loading during the first sweep) -> no stall (in_ready stays 1). Result C[3][3] = 00 00 40.
- Instance ACC_W=16; load A=B=[0x80]x4 twice:
  - Macro off: C[0][0] = 80 00 (wrap), sat_flag=0.
  - SATURATE_EN: C[0][0] = 7F FF, sat_flag=1.
  - Then clear -> sat_flag=0, C=0.
- Mode 00 with 3 bytes loaded, then mode 10 for 1 cycle, then mode 00 with a full load of the second-scenario pair -> C equals the second-scenario result exactly (partial bytes discarded).
